// File: rtl/param_fifo_if.sv
// Handshake and status bundle between a param_fifo and its producer/consumer.
// master drives push/pop/in_data; slave is the FIFO side.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 16
);
    localparam int CW = $clog2(FIFO_SIZE + 1);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  pushed_last;
    logic                  popped_last;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, in_data,
        input  out_data, out_valid, count, full, empty, almost_full, almost_empty,
               pushed_last, popped_last, overflow, underflow
    );

    modport slave (
        input  push, pop, in_data,
        output out_data, out_valid, count, full, empty, almost_full, almost_empty,
               pushed_last, popped_last, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Single-clock FIFO of any depth >= 2 with occupancy, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read on pop.
module param_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_SIZE          = 16,
    parameter int ALMOST_FULL_LEVEL  = 14,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        clear,
    param_fifo_if.slave bus
);
    localparam int CW = $clog2(FIFO_SIZE + 1);
    localparam int PW = $clog2(FIFO_SIZE);

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_SIZE);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_SIZE - 1);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_SIZE];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_next_s;
    logic [PW-1:0]         rd_ptr_next_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] out_data_next_s;
    logic                  out_valid_r;
    logic                  out_valid_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  pushed_last_r;
    logic                  popped_last_r;
    logic                  pushed_last_next_s;
    logic                  popped_last_next_s;
    logic                  overflow_r;
    logic                  underflow_r;

    // Depth need not be a power of two, so wrap by compare rather than masking.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Acceptance, next pointers and next occupancy.
    always_comb begin
        push_ok_s     = bus.push && (!full_r || bus.pop);
        pop_ok_s      = bus.pop && !empty_r;
        wr_ptr_next_s = push_ok_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_next_s = pop_ok_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Last-slot markers: an accepted pop clears pushed_last, an accepted push clears popped_last.
    always_comb begin
        if (push_ok_s && !pop_ok_s && (count_next_s == FULL_CNT)) begin
            pushed_last_next_s = 1'b1;
        end else if (pop_ok_s) begin
            pushed_last_next_s = 1'b0;
        end else begin
            pushed_last_next_s = pushed_last_r;
        end
        if (pop_ok_s && !push_ok_s && (count_next_s == '0)) begin
            popped_last_next_s = 1'b1;
        end else if (push_ok_s) begin
            popped_last_next_s = 1'b0;
        end else begin
            popped_last_next_s = popped_last_r;
        end
    end

    // Next read-port value for the selected read mode.
    always_comb begin
`ifdef FIFO_FWFT_EN
        out_valid_next_s = (count_next_s != '0);
        if (count_next_s == '0) begin
            out_data_next_s = out_data_r;
        end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
            // The entry being written this edge becomes the head: bypass the memory.
            out_data_next_s = bus.in_data;
        end else begin
            out_data_next_s = mem_r[rd_ptr_next_s];
        end
`else
        out_valid_next_s = pop_ok_s;
        if (pop_ok_s) begin
            out_data_next_s = mem_r[rd_ptr_r];
        end else begin
            out_data_next_s = out_data_r;
        end
`endif
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers, occupancy, flags and read port.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            pushed_last_r  <= 1'b0;
            popped_last_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            out_data_r     <= '0;
            out_valid_r    <= 1'b0;
        end else if (clear) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            pushed_last_r  <= 1'b0;
            popped_last_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            out_data_r     <= '0;
            out_valid_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            full_r         <= (count_next_s == FULL_CNT);
            empty_r        <= (count_next_s == '0);
            almost_full_r  <= (count_next_s >= AF_CNT);
            almost_empty_r <= (count_next_s <= AE_CNT);
            pushed_last_r  <= pushed_last_next_s;
            popped_last_r  <= popped_last_next_s;
            overflow_r     <= overflow_r  || (bus.push && !push_ok_s);
            underflow_r    <= underflow_r || (bus.pop && !pop_ok_s);
            out_data_r     <= out_data_next_s;
            out_valid_r    <= out_valid_next_s;
        end
    end

    assign bus.out_data     = out_data_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.count        = count_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.pushed_last  = pushed_last_r;
    assign bus.popped_last  = popped_last_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule
